saph_line_sequencer: RTL
========================

SAPH_LINE_SEQUENCER -- requirements
Module: saph_line_sequencer

Interface
REQ-001 SHALL have parameter coord_bits, default 12: unsigned screen coordinate width.
REQ-002 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports cmd_valid input 1 / cmd_ready output 1: line command handshake.
REQ-005 SHALL have ports cmd_x0, cmd_y0, cmd_x1, cmd_y1  input  coord_bits each: line start and end pixel.
REQ-006 SHALL have port ras_latch  output  1  drives rasterizer latch (loads start/end).
REQ-007 SHALL have port ras_count  output  1  drives rasterizer increment enable.
REQ-008 SHALL have ports ras_x, ras_y  input  coord_bits each: integer part of rasterizer current point.
REQ-009 SHALL have ports frag_valid output 1 / frag_ready input 1: fragment handshake.
REQ-010 SHALL have ports frag_x, frag_y  output  coord_bits each, frag_last  output  1: fragment position and end-of-line flag.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, LATCH, EMIT.
REQ-013 IDLE: cmd_ready=1; on cmd_valid, capture the command, assert ras_latch for exactly the next cycle (state LATCH).
REQ-014 On capture, remaining SHALL load max(|x1-x0|, |y1-y0|); counter width coord_bits, computed without overflow via a coord_bits+1 signed difference.
REQ-015 LATCH -> EMIT unconditionally after one cycle; ras_count=0 in LATCH.
REQ-016 EMIT: frag_valid=1, frag_x/frag_y combinationally equal ras_x/ras_y, frag_last=(remaining==0).
REQ-017 ras_count SHALL equal frag_valid & frag_ready & !frag_last (combinational); rasterizer advances only on an accepted non-last fragment.
REQ-018 On an accepted non-last fragment, remaining SHALL decrement by 1; on an accepted last fragment, state -> IDLE.
REQ-019 While frag_valid & !frag_ready, ras_count=0 so frag_x/frag_y/frag_last remain stable.
REQ-020 Zero-length line (start==end) SHALL emit exactly one fragment with frag_last=1.
REQ-021 Fragments per line SHALL be remaining_initial+1; throughput one fragment/cycle with frag_ready held high.
REQ-022 cmd_ready=0 outside IDLE; a cmd_valid in the cycle the last fragment is accepted is not accepted until the following IDLE cycle.
REQ-023 ras_latch and ras_count SHALL never be high in the same cycle.
REQ-024 Command latency: cmd accept at cycle N -> ras_latch at N+1 -> first frag_valid at N+2.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, remaining=0, captured command=0.
REQ-026 During reset: cmd_ready=0, ras_latch=0, ras_count=0, frag_valid=0, frag_last=0, busy=0; frag_x/frag_y follow ras_x/ras_y (don't-care).
REQ-027 Reset asserted mid-line SHALL abandon the line with no further fragments; cmd_ready=1 in the first cycle after rst_n deasserts.

Structure
REQ-028 saph_defines.svh SHALL hold coord_bits default constant and the state enum typedef (saph_lseq_state_t).
REQ-029 A sub-module saph_abs_diff (|a-b| for coord_bits operands) SHALL compute the two deltas; max selection stays in the parent.
REQ-030 Rasterizer itself is external; connected only via ras_* ports.

Verification
REQ-031 Horizontal line (0,0)->(5,0), frag_ready=1 -> 6 fragments on consecutive cycles, last flagged on 6th, first at cmd+2.
REQ-032 Point line (7,7)->(7,7) -> exactly 1 fragment (7,7), frag_last=1, ras_count never asserted.
REQ-033 Steep line (3,10)->(1,2), frag_ready toggling 1/0 -> 9 fragments, frag_x/frag_y stable during stalls, ras_count pulses = 8.
REQ-034 Full-range line (0,0)->(4095,4095) -> 4096 fragments, no counter overflow, last on 4096th.
REQ-035 Reset asserted after 3 fragments of a 10-fragment line -> outputs at reset values immediately, next command accepted cleanly.
REQ-036 Back-to-back commands with cmd_valid held -> second accepted one cycle after last fragment of first; ras_latch/ras_count never coincide.

Source files
------------

// File: rtl/saph_line_sequencer_pkg.sv
// Package wrapper that exposes the shared defines to the line sequencer files.
package saph_line_sequencer_pkg;
  `include "saph_defines.svh"
endpackage

// File: rtl/saph_abs_diff.sv
// Unsigned absolute difference |a-b|, formed from a one-bit-wider signed difference.
module saph_abs_diff #(
  parameter int COORD_W = 12
) (
  input  logic [COORD_W-1:0] i_a,
  input  logic [COORD_W-1:0] i_b,
  output logic [COORD_W-1:0] o_d
);

  logic signed [COORD_W:0] w_diff;

  assign w_diff = $signed({1'b0, i_a}) - $signed({1'b0, i_b});
  // Negating only the low bits is exact because the magnitude always fits COORD_W bits.
  assign o_d = w_diff[COORD_W] ? (~w_diff[COORD_W-1:0] + 1'b1) : w_diff[COORD_W-1:0];

endmodule

// File: rtl/saph_defines.svh
// Shared constants and the line-sequencer state type.
`ifndef SAPH_DEFINES_SVH
`define SAPH_DEFINES_SVH

localparam int SAPH_COORD_BITS = 12;

typedef enum logic [1:0] {
  ST_IDLE  = 2'd0,
  ST_LATCH = 2'd1,
  ST_EMIT  = 2'd2
} saph_lseq_state_t;

`endif

// File: rtl/saph_line_sequencer.sv
// Sequences one line command into a stream of fragments by stepping an external rasterizer.
module saph_line_sequencer
  import saph_line_sequencer_pkg::*;
#(
  parameter int coord_bits = SAPH_COORD_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [coord_bits-1:0] cmd_x0,
  input  logic [coord_bits-1:0] cmd_y0,
  input  logic [coord_bits-1:0] cmd_x1,
  input  logic [coord_bits-1:0] cmd_y1,
  output logic                  ras_latch,
  output logic                  ras_count,
  input  logic [coord_bits-1:0] ras_x,
  input  logic [coord_bits-1:0] ras_y,
  output logic                  frag_valid,
  input  logic                  frag_ready,
  output logic [coord_bits-1:0] frag_x,
  output logic [coord_bits-1:0] frag_y,
  output logic                  frag_last,
  output logic                  busy
);

  saph_lseq_state_t      r_state;
  saph_lseq_state_t      w_state_nxt;
  logic [coord_bits-1:0] r_x0, r_y0, r_x1, r_y1;
  logic [coord_bits-1:0] r_remaining;
  logic [coord_bits-1:0] w_dx, w_dy, w_span;
  logic                  w_capture;

  saph_abs_diff #(.COORD_W(coord_bits)) u_abs_dx (
    .i_a (r_x1),
    .i_b (r_x0),
    .o_d (w_dx)
  );

  saph_abs_diff #(.COORD_W(coord_bits)) u_abs_dy (
    .i_a (r_y1),
    .i_b (r_y0),
    .o_d (w_dy)
  );

  assign w_span = (w_dx >= w_dy) ? w_dx : w_dy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0 <= '0;
      r_y0 <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
    end else if (w_capture) begin
      r_x0 <= cmd_x0;
      r_y0 <= cmd_y0;
      r_x1 <= cmd_x1;
      r_y1 <= cmd_y1;
    end
  end

  // The span is taken from the captured endpoints while the rasterizer latches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
    end else if (r_state == ST_LATCH) begin
      r_remaining <= w_span;
    end else if (ras_count) begin
      r_remaining <= r_remaining - 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    cmd_ready   = 1'b0;
    ras_latch   = 1'b0;
    ras_count   = 1'b0;
    frag_valid  = 1'b0;
    frag_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: begin
        ras_latch   = 1'b1;
        w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        frag_valid = 1'b1;
        frag_last  = (r_remaining == '0);
        // The rasterizer only steps on an accepted non-last fragment, so stalls hold the point.
        if (frag_ready) begin
          if (r_remaining == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            ras_count = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign frag_x = ras_x;
  assign frag_y = ras_y;
  assign busy   = (r_state != ST_IDLE);

endmodule
